// File: rtl/boot_loader.sv
// boot_loader: byte-stream image loader that fills instruction memory and releases the core after a checksum check
module boot_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_byte,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_run,
  output logic              busy,
  output logic              err,
  output logic [ADDR_W:0]   words_loaded
);
  typedef enum logic [2:0] {LEN, DATA, CSUM, RUN, ERR} state_t;
  localparam logic [31:0] DEPTH = 32'd1 << ADDR_W;
  state_t      state;
  logic [1:0]  byte_idx;
  logic [31:0] len, word;
  logic [7:0]  csum;
  logic        take, len_bad, last_word;
  logic [31:0] len_next, word_next;
  assign take      = in_valid && in_ready;
  assign len_next  = {in_byte, len[31:8]};
  assign word_next = {in_byte, word[31:8]};
  assign len_bad   = len_next == 32'd0 || len_next > DEPTH;
  assign last_word = 32'(words_loaded) + 32'd1 == len;
  // Byte-accepting state machine; every output is registered and RUN/ERR are terminal until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= LEN;
      byte_idx     <= '0;
      len          <= '0;
      word         <= '0;
      csum         <= '0;
      in_ready     <= 1'b1;
      busy         <= 1'b1;
      err          <= 1'b0;
      core_run     <= 1'b0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (take) begin
        case (state)
          LEN: begin
            len      <= len_next;
            byte_idx <= byte_idx + 2'd1;
            csum     <= csum ^ in_byte;
            if (byte_idx == 2'd3) begin
              if (len_bad) begin
                state    <= ERR;
                in_ready <= 1'b0;
                busy     <= 1'b0;
                err      <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
          DATA: begin
            word     <= word_next;
            byte_idx <= byte_idx + 2'd1;
            csum     <= csum ^ in_byte;
            if (byte_idx == 2'd3) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[ADDR_W-1:0];
              imem_wdata   <= word_next;
              words_loaded <= words_loaded + {{ADDR_W{1'b0}}, 1'b1};
              if (last_word) state <= CSUM;
            end
          end
          CSUM: begin
            in_ready <= 1'b0;
            busy     <= 1'b0;
            if (in_byte == csum) begin
              state    <= RUN;
              core_run <= 1'b1;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_boot_loader.sv
// tb_boot_loader: randomized stream stimulus checked every cycle against a byte-history model of the loader
module tb_boot_loader;
  localparam int AW = 8;
  typedef logic [7:0] bq_t[$];
  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0;
  logic [7:0]    in_byte = 8'h00;
  logic          in_ready, imem_we, core_run, busy, err;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   words_loaded;
  int            compared = 0, mismatched = 0, we_count = 0;
  bit            live = 1'b0, acc_last = 1'b0;
  logic [7:0]    q[$];
  logic [31:0]   img[256];
  always #5 clk = ~clk;
  boot_loader #(.ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_byte(in_byte),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_run(core_run),
    .busy(busy), .err(err), .words_loaded(words_loaded)
  );
  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic int unsigned m_len();
    return q.size() >= 4 ? {q[3], q[2], q[1], q[0]} : 32'd0;
  endfunction
  function automatic bit m_bad();
    return q.size() >= 4 && (m_len() == 0 || m_len() > (32'd1 << AW));
  endfunction
  function automatic bit m_done();
    return q.size() >= 4 && !m_bad() && q.size() == 4 + 4 * m_len() + 1;
  endfunction
  function automatic bit m_ready();
    return !m_bad() && !m_done();
  endfunction
  function automatic int m_wl();
    int w;
    if (q.size() < 4 || m_bad()) return 0;
    w = (q.size() - 4) / 4;
    return w > int'(m_len()) ? int'(m_len()) : w;
  endfunction
  function automatic logic [31:0] m_word(input int i);
    return {q[4*i+7], q[4*i+6], q[4*i+5], q[4*i+4]};
  endfunction
  function automatic bit m_csum_ok();
    logic [7:0] x = 8'h00;
    for (int i = 0; i < q.size() - 1; i++) x ^= q[i];
    return x == q[q.size()-1];
  endfunction
  // model: record the accepted byte history as seen at each rising edge
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      acc_last = 1'b0;
      live = 1'b1;
    end else if (live) begin
      acc_last = in_valid && m_ready();
      if (acc_last) q.push_back(in_byte);
    end
  end
  // compare every DUT output against the model once per cycle
  always @(negedge clk) begin
    int k, wl;
    bit done, ok, we;
    if (live) begin
      k = q.size();
      wl = m_wl();
      done = m_done();
      ok = done && m_csum_ok();
      we = acc_last && k >= 8 && !m_bad() && (k - 4) % 4 == 0;
      chk("in_ready", 33'(in_ready), 33'(m_ready()));
      chk("busy", 33'(busy), 33'(m_ready()));
      chk("err", 33'(err), 33'(m_bad() || (done && !ok)));
      chk("core_run", 33'(core_run), 33'(ok));
      chk("imem_we", 33'(imem_we), 33'(we));
      chk("words_loaded", 33'(words_loaded), 33'(wl));
      chk("imem_addr", 33'(imem_addr), wl > 0 ? 33'(wl - 1) : 33'd0);
      chk("imem_wdata", 33'(imem_wdata), wl > 0 ? 33'(m_word(wl - 1)) : 33'd0);
      if (imem_we === 1'b1) we_count++;
    end
  end
  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    we_count = 0;
  endtask
  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic send_byte(input logic [7:0] b, input int idle_pct);
    bit rdy;
    while (int'($urandom_range(99)) < idle_pct) begin
      in_valid = 1'b0;
      in_byte = 8'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_byte = b;
    for (int t = 0; t < 4; t++) begin
      rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    in_valid = 1'b0;
  endtask
  task automatic send_stream(input bq_t s, input int idle_pct);
    foreach (s[i]) send_byte(s[i], idle_pct);
  endtask
  task automatic make_image(input int unsigned n, input int nw, input bit flip, output bq_t s);
    logic [7:0] x = 8'h00;
    s = {};
    for (int i = 0; i < 4; i++) s.push_back(8'(n >> (8 * i)));
    for (int w = 0; w < nw; w++)
      for (int i = 0; i < 4; i++) s.push_back(8'(img[w] >> (8 * i)));
    foreach (s[i]) x ^= s[i];
    s.push_back(flip ? x ^ 8'h01 : x);
  endtask
  initial begin
    bq_t s;
    for (int i = 0; i < 256; i++) img[i] = $urandom;
    idle(1);
    do_reset();
    s = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hC2};
    send_stream(s, 0);
    idle(2);
    chk("t1_writes", 33'(we_count), 33'd1);
    chk("t1_addr", 33'(imem_addr), 33'd0);
    chk("t1_data", 33'(imem_wdata), 33'h0_0050_0093);
    chk("t1_run", 33'(core_run), 33'd1);
    chk("t1_err", 33'(err), 33'd0);
    do_reset();
    s[8] = 8'hC3;
    send_stream(s, 0);
    idle(2);
    chk("t2_writes", 33'(we_count), 33'd1);
    chk("t2_err", 33'(err), 33'd1);
    chk("t2_run", 33'(core_run), 33'd0);
    chk("t2_ready", 33'(in_ready), 33'd0);
    do_reset();
    s = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    send_stream(s, 0);
    idle(2);
    chk("t3_err", 33'(err), 33'd1);
    chk("t3_writes", 33'(we_count), 33'd0);
    do_reset();
    s = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h11, 8'h22};
    send_stream(s, 0);
    idle(2);
    chk("t4_err257", 33'(err), 33'd1);
    do_reset();
    make_image(256, 256, 1'b0, s);
    send_stream(s, 0);
    idle(2);
    chk("t4_writes", 33'(we_count), 33'd256);
    chk("t4_words", 33'(words_loaded), 33'd256);
    chk("t4_run", 33'(core_run), 33'd1);
    for (int g = 0; g < 2; g++) begin
      do_reset();
      make_image(3, 3, 1'b0, s);
      send_stream(s, g == 0 ? 0 : 30);
      idle(2);
      chk("t5_writes", 33'(we_count), 33'd3);
      chk("t5_last", 33'(imem_wdata), 33'(img[2]));
      chk("t5_run", 33'(core_run), 33'd1);
    end
    do_reset();
    make_image(2, 2, 1'b0, s);
    for (int i = 0; i < 6; i++) send_byte(s[i], 0);
    do_reset();
    idle(1);
    chk("t6_words", 33'(words_loaded), 33'd0);
    chk("t6_ready", 33'(in_ready), 33'd1);
    chk("t6_writes", 33'(we_count), 33'd0);
    send_stream(s, 0);
    idle(2);
    chk("t6_writes2", 33'(we_count), 33'd2);
    chk("t6_run", 33'(core_run), 33'd1);
    for (int r = 0; r < 8; r++) begin
      do_reset();
      for (int i = 0; i < 8; i++) img[i] = $urandom;
      make_image($urandom_range(1, 8), 8, 1'($urandom_range(1)), s);
      send_stream(s, int'($urandom_range(40)));
      idle(3);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
